// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared types and constants for the RAM-to-byte-stream dumper
package ram_stream_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

  // Little-endian lane pick: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_t lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - holds one 32-bit word and hands it out byte by byte
module word_serializer
  import ram_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        word_last,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        byte_last,
  output logic        word_done
);

  logic [31:0] word_q;
  lane_t       lane_q;
  logic        valid_q;
  logic        last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      lane_q  <= '0;
      valid_q <= 1'b1;
      last_q  <= word_last;
    end else if (valid_q && byte_ready) begin
      lane_q <= lane_q + 1'b1;
      if (lane_q == LAST_LANE) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Data and last are pure functions of held state, so they stay put while stalled.
  assign byte_data  = lane_byte(word_q, lane_q);
  assign byte_valid = valid_q;
  assign byte_last  = valid_q && last_q && (lane_q == LAST_LANE);
  assign word_done  = valid_q && byte_ready && (lane_q == LAST_LANE);

endmodule

// File: rtl/ram_to_byte_stream.sv
// rtl/ram_to_byte_stream.sv - reads a block of RAM words and streams them out as bytes
module ram_to_byte_stream
  import ram_stream_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              err_q;

  logic              rd_load;
  logic              rd_timeout;
  logic              last_word;
  logic              word_done;
  logic              ser_valid;
  logic              ser_last;

  assign rd_load    = (state == READ) && mem_done;
  assign rd_timeout = (state == READ) && !mem_done && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign last_word  = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (mem_done) begin
          state_nxt = SEND;
        end else if (rd_timeout) begin
          state_nxt = FINISH;
        end
      end
      SEND: begin
        if (word_done) begin
          state_nxt = last_word ? FINISH : READ;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    mem_cs     = 1'b0;
    mem_oe     = 1'b0;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    case (state)
      READ: begin
        busy   = 1'b1;
        mem_cs = 1'b1;
        mem_oe = 1'b1;
      end
      SEND: begin
        busy       = 1'b1;
        byte_valid = ser_valid;
        byte_last  = ser_last;
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Address, remaining count, per-read timeout and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          tmr_q <= '0;
          if (start) begin
            addr_q <= start_addr;
            cnt_q  <= word_count;
          end
        end
        READ: begin
          if (mem_done) begin
            tmr_q <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
            if (rd_timeout) begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (word_done) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        default: begin
          tmr_q <= '0;
        end
      endcase
    end
  end

  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;

  word_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (rd_load),
    .word       (mem_rdata),
    .word_last  (last_word),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (ser_valid),
    .byte_last  (ser_last),
    .word_done  (word_done)
  );

endmodule

// File: tb/tb_ram_to_byte_stream.sv
// tb/tb_ram_to_byte_stream.sv - scoreboard bench for ram_to_byte_stream
module tb_ram_to_byte_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done, err;
  logic        mem_cs, mem_we, mem_oe;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  byte_data;
  logic        byte_valid, byte_ready, byte_last;

  logic [31:0] ram [0:63];
  logic        mem_en;
  int          mem_lat;
  int          lat_cnt;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [8:0]  sb_q[$];
  logic [31:0] addr_exp_q[$];
  int          xfers = 0, last_cnt = 0, cs_cycles = 0, valid_cycles = 0, done_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [8:0]  held;

  always #5 clk = ~clk;

  ram_to_byte_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last)
  );

  assign mem_rdata = ram[mem_addr[5:0]];
  assign mem_done  = mem_cs && mem_en && (lat_cnt >= mem_lat);

  always @(posedge clk) begin
    if (mem_cs && !mem_done) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_dump(input logic [31:0] addr, input int cnt);
    for (int w = 0; w < cnt; w++) begin
      logic [31:0] a;
      logic [31:0] wd;
      a  = addr + w;
      wd = ram[a[5:0]];
      addr_exp_q.push_back(a);
      for (int l = 0; l < 4; l++) begin
        sb_q.push_back({wd[8*l +: 8], (w == cnt - 1) && (l == 3)});
      end
    end
  endtask

  task automatic run_dump(input logic [31:0] addr, input int cnt, input logic tog,
                          input int maxc, output int cyc, output logic err_seen);
    @(posedge clk); #1;
    start_addr = addr;
    word_count = cnt[15:0];
    start      = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    err_seen = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (done) begin
        cyc      = k;
        err_seen = err;
        break;
      end
      @(posedge clk); #1;
      if (tog) byte_ready = ~byte_ready;
    end
  endtask

  // Stream and RAM-side monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_cs) begin
        cs_cycles++;
        chk("rd_strobes", {mem_oe, mem_we, byte_valid}, 3'b100);
        if (mem_done) begin
          if (addr_exp_q.size() == 0) chk("addr_unexpected", mem_addr, 32'hffff_ffff);
          else chk("mem_addr", mem_addr, addr_exp_q.pop_front());
        end
      end
      if (byte_valid) begin
        valid_cycles++;
        if (hold_pend) chk("stall_hold", {byte_data, byte_last}, held);
      end else if (hold_pend) begin
        chk("stall_valid_drop", byte_valid, 1'b1);
      end
      if (byte_valid && byte_ready) begin
        xfers++;
        if (byte_last) last_cnt++;
        if (sb_q.size() == 0) chk("byte_unexpected", {byte_data, byte_last}, 9'h1ff);
        else chk("byte", {byte_data, byte_last}, sb_q.pop_front());
      end
      hold_pend = byte_valid && !byte_ready;
      held      = {byte_data, byte_last};
      if (done) done_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic e;
    int   b_cs, b_v, b_x, b_l, b_d;
    logic got;

    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    byte_ready = 1'b1;
    mem_en     = 1'b1;
    mem_lat    = 0;
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[16] = 32'h4433_2211;

    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, done, err, mem_cs, mem_oe, mem_we, byte_valid, byte_last}, 8'h00);
    chk("reset_data", {byte_data, mem_addr}, 40'h0);
    rst_n = 1'b1;

    // Single word: four back-to-back bytes, then done.
    b_cs = cs_cycles; b_l = last_cnt;
    expect_dump(32'h10, 1);
    run_dump(32'h10, 1, 1'b0, 50, cyc, e);
    chk("w1_cycles", cyc, 6);
    chk("w1_err", e, 1'b0);
    chk("w1_reads", cs_cycles - b_cs, 1);
    chk("w1_lasts", last_cnt - b_l, 1);
    chk("w1_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("w1_idle", {busy, done}, 2'b00);

    // Three words from address 0.
    b_l = last_cnt; b_x = xfers;
    expect_dump(32'h0, 3);
    run_dump(32'h0, 3, 1'b0, 80, cyc, e);
    chk("w3_cycles", cyc, 16);
    chk("w3_bytes", xfers - b_x, 12);
    chk("w3_lasts", last_cnt - b_l, 1);
    chk("w3_addr_empty", addr_exp_q.size(), 0);

    // Consumer stalling every other cycle, slow RAM.
    mem_lat = 2;
    b_x = xfers; b_l = last_cnt;
    expect_dump(32'h20, 2);
    run_dump(32'h20, 2, 1'b1, 100, cyc, e);
    byte_ready = 1'b1;
    mem_lat    = 0;
    chk("tog_done", cyc > 0, 1'b1);
    chk("tog_bytes", xfers - b_x, 8);
    chk("tog_lasts", last_cnt - b_l, 1);
    chk("tog_sb_empty", sb_q.size(), 0);

    // Zero-length dump.
    b_cs = cs_cycles; b_v = valid_cycles;
    run_dump(32'h7, 0, 1'b0, 20, cyc, e);
    chk("zero_cycles", cyc, 1);
    chk("zero_busy", busy, 1'b1);
    chk("zero_reads", cs_cycles - b_cs, 0);
    chk("zero_valid", valid_cycles - b_v, 0);

    // RAM never answers: timeout after TIMEOUT read cycles.
    mem_en = 1'b0;
    b_cs = cs_cycles; b_v = valid_cycles;
    run_dump(32'h5, 2, 1'b0, 200, cyc, e);
    chk("to_cycles", cyc, 65);
    chk("to_err", e, 1'b1);
    chk("to_reads", cs_cycles - b_cs, 64);
    chk("to_valid", valid_cycles - b_v, 0);
    @(negedge clk);
    chk("to_idle", {busy, done, err}, 3'b000);
    mem_en = 1'b1;

    // Reset mid-word aborts the dump silently.
    b_x = xfers; b_d = done_cnt;
    expect_dump(32'h30, 2);
    @(posedge clk); #1;
    start_addr = 32'h30;
    word_count = 16'd2;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (xfers - b_x >= 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_reached", got, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {busy, done, err, mem_cs, mem_oe, mem_we, byte_valid, byte_last}, 8'h00);
    chk("rst_data", {byte_data, mem_addr}, 40'h0);
    repeat (2) @(negedge clk);
    sb_q.delete();
    addr_exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", done_cnt - b_d, 0);
    chk("rst_idle", busy, 1'b0);

    expect_dump(32'h10, 1);
    run_dump(32'h10, 1, 1'b0, 50, cyc, e);
    chk("post_rst_cycles", cyc, 6);
    chk("post_rst_sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
